// File: rtl/seg_scan6.sv
// rtl/seg_scan6.sv - six-digit multiplexed 7-segment display driver
//
// Purpose: takes a frame-coherent snapshot of six BCD digits (HH:MM:SS) and
// time-multiplexes them onto one shared segment bus. Each digit slot lasts
// SCAN_DIV cycles of CP; digit enables are one-hot, active-low.
//
// Ports:
//   CP      in   1  system clock
//   CR      in   1  synchronous active-high reset
//   HourH   in   4  hours tens, BCD
//   HourL   in   4  hours units, BCD
//   MinH    in   4  minutes tens, BCD
//   MinL    in   4  minutes units, BCD
//   SecH    in   4  seconds tens, BCD
//   SecL    in   4  seconds units, BCD
//   Blank   in   1  1 = all digits dark, scanning keeps running
//   Seg     out  7  segments a..g (Seg[0]=a), active-high
//   Dp      out  1  decimal point, active-high (lit right of MinL and HourL)
//   DigSel  out  6  digit enables, one-hot, active-low
//
// Optional build macro: LEAD_ZERO_BLANK_EN
//   defined   -> a zero hours-tens digit leaves slot 5 dark
//   undefined -> a zero hours-tens digit is shown as "0"

module seg_scan6 #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       CP,
  input  logic       CR,
  input  logic [3:0] HourH,
  input  logic [3:0] HourL,
  input  logic [3:0] MinH,
  input  logic [3:0] MinL,
  input  logic [3:0] SecH,
  input  logic [3:0] SecL,
  input  logic       Blank,
  output logic [6:0] Seg,
  output logic       Dp,
  output logic [5:0] DigSel
);

  localparam int            CW      = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [23:0]   r_snap;    // {HourH, HourL, MinH, MinL, SecH, SecL}
  logic          r_first;   // set until the first capture after reset
  logic [6:0]    r_seg;
  logic          r_dp;
  logic [5:0]    r_digsel;

  logic          w_tick;
  logic          w_frame_end;
  logic [3:0]    w_digit;
  logic          w_dp;
  logic [5:0]    w_sel;
  logic          w_lz;

  assign w_tick      = (r_cnt == CNT_MAX);
  assign w_frame_end = w_tick && (r_idx == 3'd5);

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    bcd_to_seg = 7'h3F;
      4'd1:    bcd_to_seg = 7'h06;
      4'd2:    bcd_to_seg = 7'h5B;
      4'd3:    bcd_to_seg = 7'h4F;
      4'd4:    bcd_to_seg = 7'h66;
      4'd5:    bcd_to_seg = 7'h6D;
      4'd6:    bcd_to_seg = 7'h7D;
      4'd7:    bcd_to_seg = 7'h07;
      4'd8:    bcd_to_seg = 7'h7F;
      4'd9:    bcd_to_seg = 7'h6F;
      default: bcd_to_seg = 7'h40;  // non-BCD shown as a dash
    endcase
  endfunction

  // Slot selection from the snapshot, not the live inputs, so a whole frame
  // always comes from a single capture.
  always_comb begin
    w_digit = 4'h0;
    w_dp    = 1'b0;
    w_sel   = 6'b111111;
    case (r_idx)
      3'd0: begin w_digit = r_snap[3:0];   w_sel = 6'b111110; end
      3'd1: begin w_digit = r_snap[7:4];   w_sel = 6'b111101; end
      3'd2: begin w_digit = r_snap[11:8];  w_sel = 6'b111011; w_dp = 1'b1; end
      3'd3: begin w_digit = r_snap[15:12]; w_sel = 6'b110111; end
      3'd4: begin w_digit = r_snap[19:16]; w_sel = 6'b101111; w_dp = 1'b1; end
      3'd5: begin w_digit = r_snap[23:20]; w_sel = 6'b011111; end
      default: begin w_digit = 4'h0; w_sel = 6'b111111; end
    endcase
  end

`ifdef LEAD_ZERO_BLANK_EN
  assign w_lz = (r_idx == 3'd5) && (r_snap[23:20] == 4'd0);
`else
  assign w_lz = 1'b0;
`endif

  always_ff @(posedge CP) begin
    if (CR) begin
      r_cnt    <= '0;
      r_idx    <= 3'd0;
      r_snap   <= 24'h0;
      r_first  <= 1'b1;
      r_seg    <= 7'h00;
      r_dp     <= 1'b0;
      r_digsel <= 6'b111111;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + CW'(1);

      if (w_tick)
        r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;

      // Capture once right after reset, then only on the edge that wraps
      // idx back to 0.
      if (r_first || w_frame_end)
        r_snap <= {HourH, HourL, MinH, MinL, SecH, SecL};

      r_first <= 1'b0;

      // While r_first is set the snapshot is still the reset value, so the
      // outputs keep their reset state for that cycle.
      if (!r_first) begin
        if (Blank || w_lz) begin
          r_digsel <= 6'b111111;
          r_seg    <= 7'h00;
          r_dp     <= 1'b0;
        end else begin
          r_digsel <= w_sel;
          r_seg    <= bcd_to_seg(w_digit);
          r_dp     <= w_dp;
        end
      end
    end
  end

  assign Seg    = r_seg;
  assign Dp     = r_dp;
  assign DigSel = r_digsel;

endmodule

// File: tb/tb_seg_scan6.sv
// tb/tb_seg_scan6.sv - directed self-checking bench for seg_scan6 (SCAN_DIV=4)

module tb_seg_scan6;

  logic       CP;
  logic       CR;
  logic [3:0] HourH, HourL, MinH, MinL, SecH, SecL;
  logic       Blank;
  logic [6:0] Seg;
  logic       Dp;
  logic [5:0] DigSel;

  int checks = 0;
  int errors = 0;

  seg_scan6 #(.SCAN_DIV(4)) dut (
    .CP    (CP),
    .CR    (CR),
    .HourH (HourH),
    .HourL (HourL),
    .MinH  (MinH),
    .MinL  (MinL),
    .SecH  (SecH),
    .SecL  (SecL),
    .Blank (Blank),
    .Seg   (Seg),
    .Dp    (Dp),
    .DigSel(DigSel)
  );

  initial begin
    CP = 1'b0;
    forever #5 CP = ~CP;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CP);
      #1;
    end
  endtask

  // Edge numbering below counts CP edges after the last reset edge.
  task automatic test_reset();
    CR = 1'b1; Blank = 1'b0;
    HourH = 4'd2; HourL = 4'd3; MinH = 4'd5; MinL = 4'd9; SecH = 4'd5; SecL = 4'd8;
    step(2);
    checks++;
    if ({DigSel, Seg, Dp} !== {6'b111111, 7'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got DigSel=%b Seg=%h Dp=%b, want 111111/00/0", DigSel, Seg, Dp);
    end
    CR = 1'b0;
    step(1);  // edge 1
    checks++;
    if ({DigSel, Seg, Dp} !== {6'b111111, 7'h00, 1'b0}) begin
      errors++;
      $display("FAIL release_hold: got DigSel=%b Seg=%h Dp=%b, want 111111/00/0", DigSel, Seg, Dp);
    end
    step(1);  // edge 2
    checks++;
    if ({DigSel, Seg, Dp} !== {6'b111110, 7'h7F, 1'b0}) begin
      errors++;
      $display("FAIL first_digit: got DigSel=%b Seg=%h Dp=%b, want 111110/7f/0", DigSel, Seg, Dp);
    end
  endtask

  task automatic test_scan();
    logic [13:0] tab [0:5];
    tab = '{ {6'b111101, 7'h6D, 1'b0},
             {6'b111011, 7'h6F, 1'b1},
             {6'b110111, 7'h6D, 1'b0},
             {6'b101111, 7'h4F, 1'b1},
             {6'b011111, 7'h5B, 1'b0},
             {6'b111110, 7'h7F, 1'b0} };
    // idx1 first appears at edge 5, then every 4 edges; wraps to idx0 at 25
    for (int i = 0; i < 6; i++) begin
      step(i == 0 ? 3 : 4);
      checks++;
      if ({DigSel, Seg, Dp} !== tab[i]) begin
        errors++;
        $display("FAIL scan_slot%0d: got DigSel=%b Seg=%h Dp=%b, want %b/%h/%b",
                 i, DigSel, Seg, Dp, tab[i][13:8], tab[i][7:1], tab[i][0]);
      end
    end
  endtask

  task automatic test_coherence();
    SecL = 4'd9;  // at edge 25, idx0 currently showing 8
    step(1);      // edge 26
    checks++;
    if ({DigSel, Seg} !== {6'b111110, 7'h7F}) begin
      errors++;
      $display("FAIL coh_hold: got DigSel=%b Seg=%h, want 111110/7f", DigSel, Seg);
    end
    step(19);     // edge 45, idx5
    checks++;
    if ({DigSel, Seg, Dp} !== {6'b011111, 7'h5B, 1'b0}) begin
      errors++;
      $display("FAIL coh_idx5: got DigSel=%b Seg=%h Dp=%b, want 011111/5b/0", DigSel, Seg, Dp);
    end
    step(4);      // edge 49, new frame
    checks++;
    if ({DigSel, Seg, Dp} !== {6'b111110, 7'h6F, 1'b0}) begin
      errors++;
      $display("FAIL coh_next: got DigSel=%b Seg=%h Dp=%b, want 111110/6f/0", DigSel, Seg, Dp);
    end
  endtask

  task automatic test_dp_invalid();
    MinL = 4'hC;  // at edge 49
    step(8);      // edge 57, idx2 from the older snapshot
    checks++;
    if ({DigSel, Seg, Dp} !== {6'b111011, 7'h6F, 1'b1}) begin
      errors++;
      $display("FAIL dp_old_minl: got DigSel=%b Seg=%h Dp=%b, want 111011/6f/1", DigSel, Seg, Dp);
    end
    step(16);     // edge 73, idx0
    checks++;
    if ({DigSel, Seg, Dp} !== {6'b111110, 7'h6F, 1'b0}) begin
      errors++;
      $display("FAIL dp_idx0: got DigSel=%b Seg=%h Dp=%b, want 111110/6f/0", DigSel, Seg, Dp);
    end
    step(8);      // edge 81, idx2 with MinL=C
    checks++;
    if ({DigSel, Seg, Dp} !== {6'b111011, 7'h40, 1'b1}) begin
      errors++;
      $display("FAIL dp_invalid: got DigSel=%b Seg=%h Dp=%b, want 111011/40/1", DigSel, Seg, Dp);
    end
    step(8);      // edge 89, idx4
    checks++;
    if ({DigSel, Seg, Dp} !== {6'b101111, 7'h4F, 1'b1}) begin
      errors++;
      $display("FAIL dp_idx4: got DigSel=%b Seg=%h Dp=%b, want 101111/4f/1", DigSel, Seg, Dp);
    end
  endtask

  task automatic test_blank();
    step(13);     // edge 102, idx1 showing
    Blank = 1'b1;
    step(1);      // edge 103
    checks++;
    if ({DigSel, Seg, Dp} !== {6'b111111, 7'h00, 1'b0}) begin
      errors++;
      $display("FAIL blank_on: got DigSel=%b Seg=%h Dp=%b, want 111111/00/0", DigSel, Seg, Dp);
    end
    step(9);      // edge 112, ten edges with Blank=1
    checks++;
    if (DigSel !== 6'b111111) begin
      errors++;
      $display("FAIL blank_hold: got DigSel=%b, want 111111", DigSel);
    end
    Blank = 1'b0;
    step(1);      // edge 113, idx has advanced to 4
    checks++;
    if ({DigSel, Seg, Dp} !== {6'b101111, 7'h4F, 1'b1}) begin
      errors++;
      $display("FAIL blank_resume: got DigSel=%b Seg=%h Dp=%b, want 101111/4f/1", DigSel, Seg, Dp);
    end
  endtask

  task automatic test_reset_mid();
    SecL = 4'd7;
    CR   = 1'b1;
    step(1);      // reset edge during idx4
    checks++;
    if ({DigSel, Seg, Dp} !== {6'b111111, 7'h00, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid: got DigSel=%b Seg=%h Dp=%b, want 111111/00/0", DigSel, Seg, Dp);
    end
    CR = 1'b0;
    step(1);      // relative edge 1
    checks++;
    if (DigSel !== 6'b111111) begin
      errors++;
      $display("FAIL rst_mid_hold: got DigSel=%b, want 111111", DigSel);
    end
    step(1);      // relative edge 2
    checks++;
    if ({DigSel, Seg, Dp} !== {6'b111110, 7'h07, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid_fresh: got DigSel=%b Seg=%h Dp=%b, want 111110/07/0", DigSel, Seg, Dp);
    end
  endtask

  task automatic test_lead_zero();
    logic [13:0] exp_lz;
`ifdef LEAD_ZERO_BLANK_EN
    exp_lz = {6'b111111, 7'h00, 1'b0};
`else
    exp_lz = {6'b011111, 7'h3F, 1'b0};
`endif
    HourH = 4'd0; // relative edge 2; captured at edge 24
    step(19);     // edge 21, idx5 still from the old snapshot
    checks++;
    if ({DigSel, Seg, Dp} !== {6'b011111, 7'h5B, 1'b0}) begin
      errors++;
      $display("FAIL lz_old: got DigSel=%b Seg=%h Dp=%b, want 011111/5b/0", DigSel, Seg, Dp);
    end
    step(24);     // edge 45, idx5 with HourH=0
    checks++;
    if ({DigSel, Seg, Dp} !== exp_lz) begin
      errors++;
      $display("FAIL lz_slot: got DigSel=%b Seg=%h Dp=%b, want %b/%h/%b",
               DigSel, Seg, Dp, exp_lz[13:8], exp_lz[7:1], exp_lz[0]);
    end
    step(4);      // edge 49, idx0 unaffected
    checks++;
    if ({DigSel, Seg, Dp} !== {6'b111110, 7'h07, 1'b0}) begin
      errors++;
      $display("FAIL lz_next: got DigSel=%b Seg=%h Dp=%b, want 111110/07/0", DigSel, Seg, Dp);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_coherence();
    test_dp_invalid();
    test_blank();
    test_reset_mid();
    test_lead_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
